// File: rtl/pll_rst_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_pipe;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases downstream reset; retries on lock timeout and tracks lock losses.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst,
  input  logic               locked,
  output logic               pll_rst,
  output logic               rst_out_n,
  output logic               ready,
  output logic [CNT_W-1:0]   lock_lost_cnt,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int CW = $clog2(max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES)) + 1;
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(STABLE_CYCLES - 1);

  logic               locked_s;
  logic [STATE_W-1:0] st, st_nxt;
  logic [CW-1:0]      cnt;
  logic               cnt_clr, retry_inc, lost_inc;

  sync_2ff u_lock_sync (
    .gclk   (clk),
    .grst_n (rst_n),
    .d      (locked),
    .q      (locked_s)
  );

  always_comb begin
    st_nxt    = st;
    retry_inc = 1'b0;
    lost_inc  = 1'b0;
    if (soft_rst) begin
      st_nxt = ST_PLL_RST;
    end else begin
      case (st)
        ST_PLL_RST:   if (cnt == PR_LAST) st_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (locked_s) st_nxt = ST_STABLE;
          else if (cnt == TO_LAST) begin
            st_nxt    = ST_PLL_RST;
            retry_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s)           st_nxt = ST_WAIT_LOCK;
          else if (cnt == SC_LAST) st_nxt = ST_RUN;
        end
        ST_RUN:       if (!locked_s) st_nxt = ST_LOST;
        ST_LOST: begin
          st_nxt   = ST_WAIT_LOCK;
          lost_inc = 1'b1;
        end
        default:      st_nxt = ST_PLL_RST;
      endcase
    end
    // soft_rst re-enters PLL_RST even from PLL_RST, so it restarts the pulse
    cnt_clr = (st_nxt != st) || soft_rst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= ST_PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      rst_out_n     <= 1'b0;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      st        <= st_nxt;
      pll_rst   <= (st_nxt == ST_PLL_RST);
      rst_out_n <= (st_nxt == ST_RUN);
      ready     <= (st_nxt == ST_RUN);
      if (cnt_clr)        cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CW'(1);
      if (retry_inc && retry_cnt != '1)    retry_cnt     <= retry_cnt + CNT_W'(1);
      if (lost_inc && lock_lost_cnt != '1) lock_lost_cnt <= lock_lost_cnt + CNT_W'(1);
    end
  end

  assign state_o = st;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small timing parameters.
module tb_pll_rst_seq;

  localparam int SC = 8, LT = 32, PR = 4, CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0, locked = 1'b0;
  logic          pll_rst, rst_out_n, ready;
  logic [CW-1:0] lock_lost_cnt, retry_cnt;
  logic [2:0]    state_o;

  int passed = 0, fails = 0, total = 0;

  pll_rst_seq #(
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (LT),
    .PLL_RST_CYCLES(PR),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst     (soft_rst),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .rst_out_n    (rst_out_n),
    .ready        (ready),
    .lock_lost_cnt(lock_lost_cnt),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int exp_st, input string tag);
    tick();
    chk({tag, ".state"}, state_o, exp_st);
    chk({tag, ".rst_out_n"}, rst_out_n, int'(exp_st == 3));
    chk({tag, ".ready"}, ready, int'(exp_st == 3));
  endtask

  initial begin
    int rises, last, cyc, hi;
    logic prev;

    // reset state
    #2;
    repeat (2) tick();
    chk("rst.state", state_o, 0);
    chk("rst.pll_rst", pll_rst, 1);
    chk("rst.rst_out_n", rst_out_n, 0);
    chk("rst.ready", ready, 0);
    chk("rst.lost", lock_lost_cnt, 0);
    chk("rst.retry", retry_cnt, 0);

    // full PLL reset pulse after release
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("pulse.pll_rst", pll_rst, 1);
      chk("pulse.state", state_o, 0);
    end
    tick();
    chk("pulse.end_pll_rst", pll_rst, 0);
    chk("pulse.end_state", state_o, 1);

    // lock after 10 cycles: RUN at edge 2+8+1
    repeat (10) step(1, "wait");
    locked = 1'b1;
    for (int i = 1; i <= 11; i++) step((i <= 2) ? 1 : ((i <= 10) ? 2 : 3), "acq");
    chk("acq.lost", lock_lost_cnt, 0);
    chk("acq.retry", retry_cnt, 0);
    chk("acq.pll_rst", pll_rst, 0);

    // lock loss in RUN goes through a single LOST cycle
    locked = 1'b0;
    step(3, "loss");
    step(3, "loss");
    step(4, "loss");
    chk("loss.pll_rst_lost", pll_rst, 0);
    step(1, "loss");
    chk("loss.cnt", lock_lost_cnt, 1);
    chk("loss.pll_rst_wait", pll_rst, 0);

    // sub-cycle glitch never reaches the synchronizer
    locked = 1'b1;
    #2;
    locked = 1'b0;
    repeat (3) step(1, "glitch");

    // lock drops mid-STABLE (seen at count 5), then relock restarts count
    locked = 1'b1;
    for (int i = 1; i <= 6; i++) step((i <= 2) ? 1 : 2, "stb");
    locked = 1'b0;
    step(2, "drop");
    step(2, "drop");
    step(1, "drop");
    locked = 1'b1;
    for (int i = 10; i <= 20; i++) step((i <= 11) ? 1 : ((i <= 19) ? 2 : 3), "relock");
    chk("relock.lost", lock_lost_cnt, 1);
    chk("relock.pll_rst", pll_rst, 0);

    // soft_rst wins over a lock loss seen in RUN
    locked = 1'b0;
    step(3, "soft");
    step(3, "soft");
    soft_rst = 1'b1;
    step(0, "soft");
    soft_rst = 1'b0;
    chk("soft.pll_rst", pll_rst, 1);
    chk("soft.lost", lock_lost_cnt, 1);
    chk("soft.retry", retry_cnt, 0);
    repeat (3) step(0, "soft_pulse");
    step(1, "soft_pulse");

    // no lock: retries every PR+LT cycles, retry_cnt saturates
    rises = 0; last = 0; cyc = 0; hi = 0; prev = pll_rst;
    while (rises < 17 && cyc < 1000) begin
      tick();
      cyc++;
      if (pll_rst) hi++;
      if (pll_rst && !prev) begin
        rises++;
        chk("to.retry", retry_cnt, (rises > 15) ? 15 : rises);
        if (rises > 1) chk("to.period", cyc - last, PR + LT);
        last = cyc;
        hi = 1;
      end
      if (!pll_rst && prev) chk("to.width", hi, PR);
      prev = pll_rst;
    end
    chk("to.rises", rises, 17);

    // async reset in the middle of STABLE
    locked = 1'b1;
    cyc = 0;
    while (state_o != 3'd2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("arst.in_stable", state_o, 2);
    repeat (3) tick();
    chk("arst.still_stable", state_o, 2);
    chk("arst.pre_lost", lock_lost_cnt, 1);
    chk("arst.pre_retry", retry_cnt, 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.state", state_o, 0);
    chk("arst.pll_rst", pll_rst, 1);
    chk("arst.rst_out_n", rst_out_n, 0);
    chk("arst.ready", ready, 0);
    chk("arst.lost", lock_lost_cnt, 0);
    chk("arst.retry", retry_cnt, 0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("arst.release_state", state_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
